wb_write_queue: RTL
===================

WB_WRITE_QUEUE -- requirements
Module: wb_write_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entries; power of two, 2..16.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous and active-high.
REQ-004 SHALL have port push_valid  input  1  producer offers a register write.
REQ-005 SHALL have port push_ready  output  1  queue can accept a push this cycle.
REQ-006 SHALL have port push_addr  input  5  destination register of the offered write.
REQ-007 SHALL have port push_data  input  32  data of the offered write.
REQ-008 SHALL have port wr_hold  input  1  file-register write port busy; no drain this cycle.
REQ-009 SHALL have port we  output  1  write enable to the file register.
REQ-010 SHALL have port write_addr  output  5  file-register write address (head entry).
REQ-011 SHALL have port write_data  output  32  file-register write data (head entry).
REQ-012 SHALL have ports lookup0_addr and lookup1_addr  input  5 each  read-port addresses checked for pending writes.
REQ-013 SHALL have ports hit0 and hit1  output  1 each  pending write exists for lookup0_addr / lookup1_addr.
REQ-014 SHALL have ports hit0_data and hit1_data  output  32 each  bypass data for lookup0 / lookup1.
REQ-015 SHALL have port count  output  $clog2(DEPTH)+1  number of valid entries.

Function
REQ-016 SHALL be an in-order FIFO of {addr, data} entries; head = oldest.
REQ-017 SHALL drive push_ready = (count < DEPTH); no combinational dependence on we or wr_hold.
REQ-018 SHALL accept a push at a rising edge when push_valid && push_ready.
REQ-019 SHALL discard an accepted push with push_addr = 0: handshake completes, count unchanged, no entry stored.
REQ-020 SHALL drive we = (count != 0) && !wr_hold, combinationally from registered state and wr_hold.
REQ-021 SHALL drive write_addr/write_data from the head entry when count != 0, else 0.
REQ-022 SHALL pop the head at a rising edge where we = 1.
REQ-023 SHALL keep count unchanged on simultaneous accepted push (addr != 0) and pop when not full; when full, push_ready = 0 regardless of the pop.
REQ-024 SHALL give push-to-write latency of one cycle: push at edge N into an empty queue with wr_hold low -> we = 1 during cycle N+1, write lands at edge N+1.
REQ-025 SHALL wrap read and write pointers modulo DEPTH with no lost or duplicated entries.
REQ-026 SHALL assert hitK when any valid entry has addr == lookupK_addr, lookupK_addr != 0.
REQ-027 SHALL drive hitK_data from the youngest matching entry, 0 when hitK = 0.
REQ-028 SHALL count the head entry being popped this cycle as valid for hit detection.
REQ-029 SHALL not treat the push offered this cycle as a hit until it is stored.
REQ-030 SHALL hold all state, with we = 0 and no pop, while wr_hold = 1.

Reset
REQ-031 SHALL, while rst = 1, clear count and pointers immediately; outputs become we = 0, push_ready = 1, hit0 = hit1 = 0, write_addr = 0, write_data = 0, hit0_data = hit1_data = 0.
REQ-032 SHALL discard all pending entries on reset mid-operation; after rst deasserts, the first push is handled as into an empty queue.
REQ-033 SHALL not require entry storage to be cleared; stale contents are never visible because validity derives from count and pointers.

Verification
REQ-034 Single write: push (addr 5, 0xDEADBEEF), wr_hold = 0 -> next cycle we = 1, write_addr = 5, write_data = 0xDEADBEEF; following cycle count = 0, we = 0.
REQ-035 Fill and hold: wr_hold = 1, push addrs 1..4 -> count = 4, push_ready = 0, we = 0; release wr_hold -> writes in order 1,2,3,4 on four consecutive cycles.
REQ-036 Bypass priority: queue holds (7, 0x11), then (7, 0x22); lookup0_addr = 7 -> hit0 = 1, hit0_data = 0x22; lookup1_addr = 0 -> hit1 = 0.
REQ-037 Zero register: push (0, 0xFFFFFFFF) -> accepted, count stays 0, we never asserts, lookup of 0 gives no hit.
REQ-038 Wrap and concurrency: 12 pushes with data = index while draining each cycle -> 12 writes in order, count never exceeds 1, no duplicates.
REQ-039 Reset mid-operation: count = 3, assert rst asynchronously between edges -> count = 0, we = 0 immediately; after release, push (9, 0x5) -> written one cycle later.

Source files
------------

// File: rtl/wb_write_queue.sv
// Posted register-write queue: in-order FIFO of {addr, data} writes drained into a
// file register, with two read-port bypass lookups returning the youngest pending write.
module wb_write_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_valid,
  output logic                     push_ready,
  input  logic [4:0]               push_addr,
  input  logic [31:0]              push_data,
  input  logic                     wr_hold,
  output logic                     we,
  output logic [4:0]               write_addr,
  output logic [31:0]              write_data,
  input  logic [4:0]               lookup0_addr,
  input  logic [4:0]               lookup1_addr,
  output logic                     hit0,
  output logic                     hit1,
  output logic [31:0]              hit0_data,
  output logic [31:0]              hit1_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]    r_addr [DEPTH];
  logic [31:0]   r_data [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  logic          w_push;
  logic          w_pop;
  logic          w_nonempty;
  logic [4:0]    w_lk_addr [2];

  assign w_nonempty = (r_count != '0);
  assign push_ready = (r_count < CW'(DEPTH));
  // Writes to register 0 complete the handshake but are never stored.
  assign w_push     = push_valid && push_ready && (push_addr != 5'd0);
  assign w_pop      = w_nonempty && !wr_hold;

  assign we         = w_pop;
  assign write_addr = w_nonempty ? r_addr[r_rd_ptr] : 5'd0;
  assign write_data = w_nonempty ? r_data[r_rd_ptr] : 32'd0;
  assign count      = r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Entry storage is left uncleared; validity comes only from pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_wr_ptr] <= push_addr;
      r_data[r_wr_ptr] <= push_data;
    end
  end

  assign w_lk_addr[0] = lookup0_addr;
  assign w_lk_addr[1] = lookup1_addr;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lookup
      logic        w_hit;
      logic [31:0] w_hit_data;

      // Scan oldest to youngest so the last match found is the youngest one.
      always_comb begin
        logic [AW-1:0] idx;
        w_hit      = 1'b0;
        w_hit_data = 32'd0;
        idx        = '0;
        for (int k = 0; k < DEPTH; k++) begin
          idx = r_rd_ptr + AW'(k);
          if ((CW'(k) < r_count) && (w_lk_addr[gi] != 5'd0) &&
              (r_addr[idx] == w_lk_addr[gi])) begin
            w_hit      = 1'b1;
            w_hit_data = r_data[idx];
          end
        end
      end
    end
  endgenerate

  assign hit0      = g_lookup[0].w_hit;
  assign hit0_data = g_lookup[0].w_hit_data;
  assign hit1      = g_lookup[1].w_hit;
  assign hit1_data = g_lookup[1].w_hit_data;

endmodule
